// File: rtl/rf_pkg.sv
// Shared types for the register-file access sequencer and its write queue.
// Default widths match the register file's data and address buses.
package rf_pkg;

  localparam int RF_DATA_W = 32;
  localparam int RF_ADDR_W = 5;

  typedef logic [RF_ADDR_W-1:0] rf_addr_t;
  typedef logic [RF_DATA_W-1:0] rf_data_t;

  typedef struct packed {
    rf_addr_t addr;
    rf_data_t data;
  } wq_entry_t;

  typedef enum logic {
    IDLE,
    RD_WAIT
  } rfc_state_e;

  function automatic logic entryHit(input logic valid, input wq_entry_t entry, input rf_addr_t addr);
    return valid && (entry.addr == addr);
  endfunction

endpackage

// File: rtl/rf_wq.sv
// In-order writeback queue; contents are presented oldest-first so the
// sequencer can compare addresses by age without knowing the pointers.
module rf_wq
  import rf_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      push_i,
  input  wq_entry_t push_entry_i,
  input  logic      pop_i,
  output logic      full_o,
  output logic      empty_o,
  output wq_entry_t entries_o [DEPTH],
  output logic      valid_o   [DEPTH]
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  wq_entry_t        mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= push_entry_i;
  end

  // Slot k is the k-th oldest pending write; slot 0 is the head.
  always_comb begin
    for (int k = 0; k < DEPTH; k++) begin
      entries_o[k] = mem_q[rd_ptr_q + PTR_W'(k)];
      valid_o[k]   = (CNT_W'(k) < count_q);
    end
  end

endmodule

// File: rtl/regfile_ctrl.sv
// Register-file access sequencer: arbitrates operand reads against queued writebacks.
// Define RF_BYPASS_EN to forward pending writes to reads instead of stalling on them.
module regfile_ctrl
  import rf_pkg::*;
#(
  parameter int DATA_W   = RF_DATA_W,
  parameter int ADDR_W   = RF_ADDR_W,
  parameter int WQ_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_req_valid,
  output logic              rd_req_ready,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  input  logic [ADDR_W-1:0] rd_addr3,
  output logic              rd_rsp_valid,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2,
  output logic [DATA_W-1:0] rd_data3,
  input  logic              wb_valid,
  output logic              wb_ready,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              rf_enable,
  output logic              rf_write,
  output logic              rf_read,
  output logic [ADDR_W-1:0] rf_raddr1,
  output logic [ADDR_W-1:0] rf_raddr2,
  output logic [ADDR_W-1:0] rf_waddr1,
  output logic [DATA_W-1:0] rf_din,
  input  logic [DATA_W-1:0] rf_dout1,
  input  logic [DATA_W-1:0] rf_dout2,
  input  logic [DATA_W-1:0] rf_dout3
);

  wq_entry_t         push_entry;
  wq_entry_t         wq_entries [WQ_DEPTH];
  logic              wq_valid   [WQ_DEPTH];
  logic              wq_full, wq_empty;

  logic [ADDR_W-1:0] op_addr    [3];
  logic [DATA_W-1:0] rf_dout    [3];
  logic [DATA_W-1:0] capture    [3];

  rfc_state_e        state_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] data_q     [3];

  logic              hazard, can_accept, rd_accept, drain, wb_push;

  assign op_addr[0] = rd_addr1;
  assign op_addr[1] = rd_addr2;
  assign op_addr[2] = rd_addr3;
  assign rf_dout[0] = rf_dout1;
  assign rf_dout[1] = rf_dout2;
  assign rf_dout[2] = rf_dout3;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = rf_addr_t'(wb_addr);
    push_entry.data = rf_data_t'(wb_data);
  end

  rf_wq #(
    .DEPTH(WQ_DEPTH)
  ) u_wq (
    .clk_i        (clk),
    .rst_i        (rst),
    .push_i       (wb_push),
    .push_entry_i (push_entry),
    .pop_i        (drain),
    .full_o       (wq_full),
    .empty_o      (wq_empty),
    .entries_o    (wq_entries),
    .valid_o      (wq_valid)
  );

`ifdef RF_BYPASS_EN
  logic              byp_hit_d  [3];
  logic              byp_hit_q  [3];
  logic [DATA_W-1:0] byp_data_d [3];
  logic [DATA_W-1:0] byp_data_q [3];

  assign hazard = 1'b0;

  // Scan oldest to youngest so the last match wins; the head being drained
  // this cycle is already on its way into the regfile and is skipped.
  always_comb begin
    for (int j = 0; j < 3; j++) begin
      byp_hit_d[j]  = 1'b0;
      byp_data_d[j] = '0;
    end
    for (int k = 0; k < WQ_DEPTH; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (entryHit(wq_valid[k] && !(k == 0 && drain), wq_entries[k], rf_addr_t'(op_addr[j]))) begin
          byp_hit_d[j]  = 1'b1;
          byp_data_d[j] = DATA_W'(wq_entries[k].data);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < 3; j++) begin
        byp_hit_q[j]  <= 1'b0;
        byp_data_q[j] <= '0;
      end
    end else if (rd_accept) begin
      byp_hit_q  <= byp_hit_d;
      byp_data_q <= byp_data_d;
    end
  end

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      capture[j] = byp_hit_q[j] ? byp_data_q[j] : rf_dout[j];
    end
  end
`else
  // Without forwarding, any pending write to an operand must land first.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < WQ_DEPTH; k++) begin
      for (int j = 0; j < 3; j++) begin
        if (entryHit(wq_valid[k], wq_entries[k], rf_addr_t'(op_addr[j]))) hazard = 1'b1;
      end
    end
  end

  always_comb begin
    for (int j = 0; j < 3; j++) begin
      capture[j] = rf_dout[j];
    end
  end
`endif

  // A full queue blocks reads, so draining whenever no read is taken also
  // covers the full-queue-first priority.
  assign can_accept   = !rst && (state_q == IDLE) && !wq_full && !hazard;
  assign rd_req_ready = can_accept;
  assign rd_accept    = rd_req_valid && can_accept;
  assign drain        = !rst && !wq_empty && !rd_accept;
  assign wb_ready     = !rst && !wq_full;
  assign wb_push      = wb_valid && wb_ready;

  assign rf_read   = rd_accept;
  assign rf_write  = drain;
  assign rf_enable = rd_accept || drain;
  assign rf_raddr1 = rd_addr1;
  assign rf_raddr2 = rd_addr2;
  assign rf_waddr1 = drain ? ADDR_W'(wq_entries[0].addr) : rd_addr3;
  assign rf_din    = DATA_W'(wq_entries[0].data);

  // The regfile presents dout the cycle after the read strobe; capture it
  // then and pulse the response the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
      for (int j = 0; j < 3; j++) data_q[j] <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (rd_accept) state_q <= RD_WAIT;
        end
        RD_WAIT: begin
          state_q     <= IDLE;
          rsp_valid_q <= 1'b1;
          for (int j = 0; j < 3; j++) data_q[j] <= capture[j];
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_rsp_valid = rsp_valid_q;
  assign rd_data1     = data_q[0];
  assign rd_data2     = data_q[1];
  assign rd_data3     = data_q[2];

endmodule

// File: tb/tb_regfile_ctrl.sv
// Self-checking bench for regfile_ctrl: behavioural regfile plus an architectural
// reference model (committed register values and an ordered list of pending writebacks).
module tb_regfile_ctrl;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;
`ifdef RF_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          rd_req_valid = 1'b0;
  logic          rd_req_ready;
  logic [AW-1:0] rd_addr1 = '0, rd_addr2 = '0, rd_addr3 = '0;
  logic          rd_rsp_valid;
  logic [DW-1:0] rd_data1, rd_data2, rd_data3;
  logic          wb_valid = 1'b0;
  logic          wb_ready;
  logic [AW-1:0] wb_addr = '0;
  logic [DW-1:0] wb_data = '0;
  logic          rf_enable, rf_write, rf_read;
  logic [AW-1:0] rf_raddr1, rf_raddr2, rf_waddr1;
  logic [DW-1:0] rf_din;
  logic [DW-1:0] rf_dout1 = '0, rf_dout2 = '0, rf_dout3 = '0;

  always #5 clk = ~clk;

  regfile_ctrl #(.DATA_W(DW), .ADDR_W(AW), .WQ_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .rd_req_valid(rd_req_valid), .rd_req_ready(rd_req_ready),
    .rd_addr1(rd_addr1), .rd_addr2(rd_addr2), .rd_addr3(rd_addr3),
    .rd_rsp_valid(rd_rsp_valid),
    .rd_data1(rd_data1), .rd_data2(rd_data2), .rd_data3(rd_data3),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_addr(wb_addr), .wb_data(wb_data),
    .rf_enable(rf_enable), .rf_write(rf_write), .rf_read(rf_read),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr1(rf_waddr1),
    .rf_din(rf_din),
    .rf_dout1(rf_dout1), .rf_dout2(rf_dout2), .rf_dout3(rf_dout3)
  );

  // Behavioural register file; r3 starts at 0x11.
  logic [DW-1:0] rfMem [32] = '{3: 32'h11, default: '0};

  always @(posedge clk) begin
    if (rf_enable && rf_write) rfMem[rf_waddr1] <= rf_din;
    if (rf_enable && rf_read) begin
      rf_dout1 <= rfMem[rf_raddr1];
      rf_dout2 <= rfMem[rf_raddr2];
      rf_dout3 <= rfMem[rf_waddr1];
    end
  end

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wb_t;

  logic [DW-1:0] arch [32] = '{3: 32'h11, default: '0};
  wb_t           pending[$];
  logic [DW-1:0] respExp [3];
  int            respDue   = -1;
  int            cycle     = 0;
  bit            busy      = 1'b0;
  bit            postReset = 1'b0;
  int            errors    = 0;
  int            checks    = 0;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s cycle=%0d observed=0x%0h expected=0x%0h", tag, cycle, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check registered and combinational outputs
  // against the model, then advance the model.
  task automatic applyStimulus(input bit r, input bit rv, input logic [AW-1:0] a1,
                               input logic [AW-1:0] a2, input logic [AW-1:0] a3,
                               input bit wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd);
    bit hz, expReady, acc, expDrain, expWbReady, expRsp;
    @(negedge clk);
    rst = r; rd_req_valid = rv; rd_addr1 = a1; rd_addr2 = a2; rd_addr3 = a3;
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    #1;
    expRsp = (respDue == cycle);
    checkOutput("rsp_valid", 32'(rd_rsp_valid), 32'(expRsp));
    if (expRsp) begin
      checkOutput("rd_data1", rd_data1, respExp[0]);
      checkOutput("rd_data2", rd_data2, respExp[1]);
      checkOutput("rd_data3", rd_data3, respExp[2]);
    end
    if (postReset) begin
      checkOutput("rd_data1_rst", rd_data1, 32'h0);
      checkOutput("rd_data2_rst", rd_data2, 32'h0);
      checkOutput("rd_data3_rst", rd_data3, 32'h0);
    end

    hz = 1'b0;
    foreach (pending[i]) if (pending[i].a == a1 || pending[i].a == a2 || pending[i].a == a3) hz = 1'b1;
    expReady   = !r && !busy && (pending.size() < DEPTH) && (BYPASS || !hz);
    acc        = rv && expReady;
    expDrain   = !r && (pending.size() > 0) && !acc;
    expWbReady = !r && (pending.size() < DEPTH);

    checkOutput("rd_req_ready", 32'(rd_req_ready), 32'(expReady));
    checkOutput("wb_ready", 32'(wb_ready), 32'(expWbReady));
    checkOutput("rf_read", 32'(rf_read), 32'(acc));
    checkOutput("rf_write", 32'(rf_write), 32'(expDrain));
    checkOutput("rf_enable", 32'(rf_enable), 32'(acc || expDrain));
    if (acc) begin
      checkOutput("rf_raddr1", 32'(rf_raddr1), 32'(a1));
      checkOutput("rf_raddr2", 32'(rf_raddr2), 32'(a2));
      checkOutput("rf_raddr3", 32'(rf_waddr1), 32'(a3));
    end
    if (expDrain) begin
      checkOutput("drain_addr", 32'(rf_waddr1), 32'(pending[0].a));
      checkOutput("drain_data", rf_din, pending[0].d);
    end

    if (r) begin
      pending.delete();
      foreach (arch[i]) arch[i] = rfMem[i];
      respDue   = -1;
      busy      = 1'b0;
      postReset = 1'b1;
    end else begin
      postReset = 1'b0;
      busy      = acc;
      if (acc) begin
        respExp[0] = arch[a1];
        respExp[1] = arch[a2];
        respExp[2] = arch[a3];
        respDue    = cycle + 2;
      end
      if (expDrain) void'(pending.pop_front());
      if (wv && expWbReady) begin
        pending.push_back('{a: wa, d: wd});
        arch[wa] = wd;
      end
    end
    cycle++;
  endtask

  initial begin
    $display("[TB] start, bypass=%0d", BYPASS);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Read (1,2,3) from an empty queue; r3 returns its preload.
    applyStimulus(0, 1, 1, 2, 3, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Reset lands in the wait cycle of a read: that read never responds.
    applyStimulus(0, 1, 1, 2, 3, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Writeback to r9 alongside an accepted read of r9, then re-read.
    applyStimulus(0, 1, 9, 0, 0, 1, 9, 32'h55);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 9, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Queued r4 write ahead of a read of r4.
    applyStimulus(0, 0, 0, 0, 0, 1, 4, 32'hAA);
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 4, 0, 0, 0, 0, 0);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Back-to-back reads and writebacks fill the queue to full.
    for (int i = 0; i < 12; i++)
      applyStimulus(0, 1, 20, 21, 22, 1, 5'(5 + i), 32'(i + 1));
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Repeated writes to r4 while reading it as operand 2.
    for (int i = 0; i < 10; i++)
      applyStimulus(0, 1, 20, 4, 21, 1, 4, 32'(i + 1));
    repeat (6) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 3000; i++)
      applyStimulus(($urandom_range(0, 199) == 0), ($urandom_range(0, 9) < 6),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    ($urandom_range(0, 9) < 7), 5'($urandom_range(0, 7)), $urandom);
    repeat (8) applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
